// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;
   localparam int REG_ADDR_W  = 4;
   localparam int FLUSH_MAX   = 3;
   localparam int FLUSH_CNT_W = $clog2(FLUSH_MAX + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } hz_state_e;
endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side hazard interface: operand/dest info in, stall/flush controls out.
interface hazard_unit_if;
   import hazard_pkg::*;

   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic [REG_ADDR_W-1:0] ex_reg_dst;
   logic                  ex_is_load;
   logic                  branch_taken;
   logic                  mem_req;
   logic                  mem_ready;
   logic                  pc_stall;
   logic                  if_id_stall;
   logic                  id_ex_stall;
   logic                  ex_mem_stall;
   logic                  if_id_flush;
   logic                  id_ex_bubble;

   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_reg_dst, ex_is_load,
             branch_taken, mem_req, mem_ready,
      input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_bubble
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_reg_dst, ex_is_load,
             branch_taken, mem_req, mem_ready,
      output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_bubble
   );
endinterface

// File: rtl/hazard_sat_cnt.sv
// Saturating event counter; clr wins over inc.
module hazard_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)                      cnt_d = '0;
      else if (inc && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: memory-wait freeze, taken-branch flush window, load-use stall.
// Optional perf counters under `HAZARD_PERF_EN.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   hazard_unit_if.slave     hz
`ifdef HAZARD_PERF_EN
   ,
   input  logic             perf_clr,
   output logic [15:0]      stall_cycles,
   output logic [15:0]      flush_count
`endif
);
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   hz_state_e              state_q, state_d;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic                   load_use, mem_wait;
   logic                   stall_all, ld_stall, flush;

   assign load_use = hz.ex_is_load &&
                     ((hz.id_rs1_used && hz.id_rs1 == hz.ex_reg_dst) ||
                      (hz.id_rs2_used && hz.id_rs2 == hz.ex_reg_dst));
   assign mem_wait = hz.mem_req && !hz.mem_ready;

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      stall_all   = 1'b0;
      ld_stall    = 1'b0;
      flush       = 1'b0;
      unique case (state_q)
         RUN: begin
            if (mem_wait) begin
               stall_all = 1'b1;
               state_d   = MEM_WAIT;
            end else if (hz.branch_taken) begin
               flush       = 1'b1;
               flush_cnt_d = FLUSH_LOAD;
               state_d     = (FLUSH_LOAD != '0) ? FLUSH : RUN;
            end else if (load_use) begin
               ld_stall = 1'b1;
            end
         end
         MEM_WAIT: begin
            // Remaining flush cycles survive the wait and resume afterwards.
            if (!hz.mem_ready) stall_all = 1'b1;
            else               state_d   = (flush_cnt_q != '0) ? FLUSH : RUN;
         end
         FLUSH: begin
            if (mem_wait) begin
               stall_all = 1'b1;
               state_d   = MEM_WAIT;
            end else begin
               flush       = 1'b1;
               flush_cnt_d = flush_cnt_q - 1'b1;
               if (flush_cnt_q == 1) state_d = RUN;
            end
         end
         default: begin
            state_d     = RUN;
            flush_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Outputs are forced low for the whole reset cycle, not just after the edge.
   assign hz.pc_stall     = !rst && (stall_all || ld_stall);
   assign hz.if_id_stall  = !rst && (stall_all || ld_stall);
   assign hz.id_ex_stall  = !rst && stall_all;
   assign hz.ex_mem_stall = !rst && stall_all;
   assign hz.if_id_flush  = !rst && flush;
   assign hz.id_ex_bubble = !rst && (flush || ld_stall);

`ifdef HAZARD_PERF_EN
   logic br_accept;
   assign br_accept = !rst && state_q == RUN && hz.branch_taken && !mem_wait;

   hazard_sat_cnt #(.W(16)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (perf_clr),
      .inc (hz.pc_stall),
      .cnt (stall_cycles)
   );

   hazard_sat_cnt #(.W(16)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .clr (perf_clr),
      .inc (br_accept),
      .cnt (flush_count)
   );
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (FLUSH_CYCLES=3); perf checks under HAZARD_PERF_EN.
module tb_hazard_unit;
   logic clk = 1'b0;
   logic rst;
   logic perf_clr;
   logic [15:0] stall_cycles, flush_count;

   hazard_unit_if hif ();

   always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
   hazard_unit #(.FLUSH_CYCLES(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .hz           (hif),
      .perf_clr     (perf_clr),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );
`else
   hazard_unit #(.FLUSH_CYCLES(3)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif)
   );
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

   typedef struct {
      string       name;
      logic [5:0]  outs;   // {pc, if_id, id_ex, ex_mem stall, if_id_flush, id_ex_bubble}
      bit          chk_perf;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Monitor: outputs are present every cycle, one expectation per cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t       e;
         logic [5:0] got;
         e   = sb.pop_front();
         got = {hif.pc_stall, hif.if_id_stall, hif.id_ex_stall, hif.ex_mem_stall,
                hif.if_id_flush, hif.id_ex_bubble};
         tests++;
         if (got !== e.outs) begin
            fails++;
            $display("FAIL %s: outs got %b want %b", e.name, got, e.outs);
         end
`ifdef HAZARD_PERF_EN
         if (e.chk_perf) begin
            tests++;
            if (stall_cycles !== e.sc || flush_count !== e.fc) begin
               fails++;
               $display("FAIL %s_perf: stall_cycles/flush_count got %0d/%0d want %0d/%0d",
                        e.name, stall_cycles, flush_count, e.sc, e.fc);
            end
         end
`endif
      end
   end

   task automatic vec(input string nm, input logic r,
                      input logic [3:0] dst, input logic ld,
                      input logic [3:0] rs1, input logic u1,
                      input logic [3:0] rs2, input logic u2,
                      input logic br, input logic mq, input logic mr, input logic pc,
                      input logic [5:0] e, input bit cp, input int sc, input int fc);
      exp_t x;
      @(posedge clk);
      #1;
      rst              = r;
      hif.ex_reg_dst   = dst;
      hif.ex_is_load   = ld;
      hif.id_rs1       = rs1;
      hif.id_rs1_used  = u1;
      hif.id_rs2       = rs2;
      hif.id_rs2_used  = u2;
      hif.branch_taken = br;
      hif.mem_req      = mq;
      hif.mem_ready    = mr;
      perf_clr         = pc;
      x.name     = nm;
      x.outs     = e;
      x.chk_perf = cp;
      x.sc       = 16'(sc);
      x.fc       = 16'(fc);
      sb.push_back(x);
   endtask

   initial begin
      rst = 1'b1;
      perf_clr = 1'b0;
      hif.ex_reg_dst = '0; hif.ex_is_load = 1'b0;
      hif.id_rs1 = '0; hif.id_rs1_used = 1'b0;
      hif.id_rs2 = '0; hif.id_rs2_used = 1'b0;
      hif.branch_taken = 1'b0; hif.mem_req = 1'b0; hif.mem_ready = 1'b0;

      //   name            r  dst ld rs1 u1 rs2 u2 br mq mr pc  expect     cp sc fc
      vec("rst_junk",      1, 5, 1, 0, 0, 5, 1, 1, 1, 0, 0, 6'b000000, 0, 0, 0);
      vec("rst_idle",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 0);
      vec("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
      vec("lu_rs2",        0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 6'b110001, 0, 0, 0);
      vec("lu_release",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 1, 0);
      vec("lu_rs2_unused", 0, 5, 1, 0, 0, 5, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
      vec("lu_r0",         0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 6'b110001, 0, 0, 0);
      vec("noload_r0",     0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
      vec("pclr",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 1, 2, 0);
      vec("after_clr",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 0);
      vec("mw1",           0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b111100, 0, 0, 0);
      vec("mw2_ignore",    0, 5, 1, 0, 0, 5, 1, 1, 1, 0, 0, 6'b111100, 0, 0, 0);
      vec("mw3",           0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b111100, 0, 0, 0);
      vec("mw_ready_br",   0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 6'b000000, 0, 0, 0);
      vec("post_mw",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 3, 0);
      vec("br",            0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000011, 0, 0, 0);
      vec("fl2_ign_lu",    0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0, 6'b000011, 0, 0, 0);
      vec("fl3",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0, 0);
      vec("post_fl",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 3, 1);
      vec("br_and_lu",     0, 5, 1, 5, 1, 0, 0, 1, 0, 0, 0, 6'b000011, 0, 0, 0);
      vec("fl_memwait",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b111100, 0, 0, 0);
      vec("mw_to_fl",      0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b000000, 0, 0, 0);
      vec("fl_resume",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0, 0);
      vec("fl_last",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0, 0);
      vec("post_fl2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 4, 2);
      vec("mem_over_br",   0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6'b111100, 0, 0, 0);
      vec("rst_in_mw",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000000, 0, 0, 0);
      vec("run_after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 0);
      vec("lu_both_r15",   0, 15, 1, 15, 1, 15, 1, 0, 0, 0, 0, 6'b110001, 0, 0, 0);
      vec("mem_hit",       0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b000000, 0, 0, 0);
      vec("br2",           0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000011, 0, 0, 0);
      vec("rst_in_fl",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
      vec("run_after_rst2",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 0);

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, range 1..3, sets the number of cycles if_id_flush/id_ex_bubble assert per taken branch.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 id_rs1, id_rs2  in  4 each  source register numbers of the instruction in ID.
REQ-005 id_rs1_used, id_rs2_used  in  1 each  the corresponding source is actually read.
REQ-006 ex_reg_dst  in  4  destination of the instruction in EX.
REQ-007 ex_is_load  in  1  EX instruction is a load with ex_reg_dst as destination.
REQ-008 branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-009 mem_req, mem_ready  in  1 each  data-memory request from MEM; memory completion.
REQ-010 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the named register.
REQ-011 if_id_flush, id_ex_bubble  out  1 each  zero IF/ID; insert a NOP into ID/EX.
REQ-012 perf_clr  in  1  clears performance counters (HAZARD_PERF_EN only).
REQ-013 stall_cycles, flush_count  out  16 each  performance counters (HAZARD_PERF_EN only).

Function
REQ-014 FSM states are RUN, MEM_WAIT and FLUSH; all outputs are combinational from the current state and inputs.
REQ-015 Load-use: ex_is_load && ((id_rs1_used && id_rs1==ex_reg_dst) || (id_rs2_used && id_rs2==ex_reg_dst)); all 16 registers are checked and none is exempt.
REQ-016 Priority within RUN is memory wait, then branch, then load-use; at most one action per cycle.
REQ-017 RUN with mem_req && !mem_ready asserts all four stall outputs, asserts no flush or bubble, and moves to MEM_WAIT.
REQ-018 MEM_WAIT asserts all four stalls while !mem_ready; in the mem_ready cycle it asserts no stalls and returns to RUN.
REQ-019 In MEM_WAIT, branch_taken and load-use are ignored; the frozen EX re-presents them after return to RUN.
REQ-020 RUN with branch_taken and no memory wait asserts if_id_flush and id_ex_bubble in that cycle, asserts no stalls, loads flush_cnt=FLUSH_CYCLES-1, and moves to FLUSH if flush_cnt>0, else stays in RUN.
REQ-021 FLUSH asserts if_id_flush and id_ex_bubble each cycle and decrements flush_cnt; it returns to RUN in the cycle flush_cnt==1 is observed.
REQ-022 In FLUSH, branch_taken and load-use are ignored; mem_req && !mem_ready takes precedence, freezes all stages, and moves to MEM_WAIT with flush_cnt held.
REQ-023 A memory wait entered from FLUSH returns to FLUSH (not RUN) on mem_ready when flush_cnt>0.
REQ-024 RUN with load-use and no higher-priority event asserts pc_stall, if_id_stall and id_ex_bubble for exactly one cycle and stays in RUN; the following cycle re-evaluates with fresh inputs.
REQ-025 A load-use stall and a branch in the same cycle resolve as a branch only.

Reset
REQ-026 While rst is high, all outputs are 0 regardless of inputs.
REQ-027 On a clock edge with rst high, state becomes RUN, flush_cnt becomes 0 and perf counters become 0, including mid-MEM_WAIT or mid-FLUSH.

Configuration
REQ-028 Macro HAZARD_PERF_EN defined: stall_cycles increments every cycle pc_stall==1.
REQ-029 Macro HAZARD_PERF_EN defined: flush_count increments once per accepted branch_taken.
REQ-030 Macro HAZARD_PERF_EN defined: both counters saturate at 16'hFFFF, and perf_clr zeroes both on the next edge, with priority over increment.
REQ-031 Macro HAZARD_PERF_EN undefined: perf_clr, stall_cycles and flush_count ports are absent, and no counter logic is present.

Structure
REQ-032 Package hazard_pkg holds the state enum (RUN, MEM_WAIT, FLUSH), REG_ADDR_W=4 and FLUSH_MAX=3.
REQ-033 Sub-module hazard_sat_cnt (16-bit saturating counter with clr and inc) is instanced twice under HAZARD_PERF_EN.

Verification
REQ-034 ex_is_load=1, ex_reg_dst=5, id_rs2=5, id_rs2_used=1 -> pc_stall, if_id_stall and id_ex_bubble high for 1 cycle, then low.
REQ-035 Same as REQ-034 but id_rs2_used=0 -> no stall or bubble.
REQ-036 mem_req=1 with mem_ready low for 3 cycles -> all four stalls high for 3 cycles and low in the mem_ready cycle; stall_cycles=3.
REQ-037 FLUSH_CYCLES=3 with a 1-cycle branch_taken pulse -> flush and bubble high for exactly 3 cycles; flush_count=1.
REQ-038 branch_taken and load-use in the same cycle -> flush and bubble only, no pc_stall.
REQ-039 rst asserted in the 2nd MEM_WAIT cycle -> outputs 0 at once; next cycle RUN with counters 0.
